// File: rtl/clint_mtimer_pkg.sv
// Shared definitions for the machine timer: register indices, CTRL fields and
// the interrupt-vector encoding that the core-local interrupt arbiter also uses.
`ifndef CLINT_MTIMER_DEFINES
`define CLINT_MTIMER_DEFINES
`define INT_WIDTH 8
`define INT_NONE  8'h00
`endif

package clint_mtimer_pkg;

  localparam int                   INT_WIDTH  = `INT_WIDTH;
  localparam logic [INT_WIDTH-1:0] INT_NONE   = `INT_NONE;
  localparam int                   INT_TIMER0 = 0;

  // Word index taken from addr_i[4:2]
  typedef enum logic [2:0] {
    REG_CTRL        = 3'd0,
    REG_MTIME_LO    = 3'd1,
    REG_MTIME_HI    = 3'd2,
    REG_MTIMECMP_LO = 3'd3,
    REG_MTIMECMP_HI = 3'd4
  } reg_idx_e;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PEND_BIT = 1;
  localparam int CTRL_DIV_LSB  = 8;
  localparam int CTRL_DIV_W    = 8;

  function automatic logic [31:0] ctrl_pack(input logic en, input logic pend,
                                            input logic [CTRL_DIV_W-1:0] div);
    logic [31:0] v;
    v = '0;
    v[CTRL_EN_BIT]                           = en;
    v[CTRL_PEND_BIT]                         = pend;
    v[CTRL_DIV_LSB +: CTRL_DIV_W]            = div;
    return v;
  endfunction

endpackage

// File: rtl/clint_mtimer_prescaler.sv
// Programmable prescaler: emits one tick every (div+1) enabled cycles.
// The count holds while disabled and restarts from zero on clr.
module clint_mtimer_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [7:0] i_div,
  input  logic       i_clr,
  output logic       o_tick
);

  logic [7:0] r_pcnt;
  logic       w_wrap;

  assign w_wrap = (r_pcnt == i_div);
  assign o_tick = i_en & w_wrap;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset branch is asynchronous through the sensitivity list.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (i_clr) begin
      r_pcnt <= '0;
    end else if (i_en) begin
      r_pcnt <= w_wrap ? 8'd0 : r_pcnt + 8'd1;
    end
  end

endmodule

// File: rtl/clint_mtimer.sv
// Machine timer: 64-bit mtime with prescaler, 64-bit mtimecmp, sticky PEND and
// a registered level interrupt toward the core-local interrupt arbiter.
module clint_mtimer
  import clint_mtimer_pkg::*;
#(
  parameter int          INT_BIT   = INT_TIMER0,
  parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic                 we_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          data_i,
  output logic [31:0]          data_o,
  output logic                 rvalid_o,
  output logic [INT_WIDTH-1:0] int_flag_o
);

  localparam logic [INT_WIDTH-1:0] INT_MASK = {{(INT_WIDTH-1){1'b0}}, 1'b1} << INT_BIT;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_en;
  logic                  r_pend;
  logic [CTRL_DIV_W-1:0] r_div;
  logic [31:0]           r_hi_shadow;

  logic       w_wr;
  logic       w_rd;
  logic [2:0] w_idx;
  logic       w_wr_ctrl;
  logic       w_wr_mtime_lo;
  logic       w_wr_mtime_hi;
  logic       w_wr_cmp_lo;
  logic       w_wr_cmp_hi;
  logic       w_tick;
  logic       w_match;
  logic       w_pend_nxt;
  logic [31:0] w_rdata;
  logic       w_unused;

  assign w_wr  = req_i & we_i;
  assign w_rd  = req_i & ~we_i;
  assign w_idx = addr_i[4:2];

  assign w_wr_ctrl     = w_wr & (w_idx == REG_CTRL);
  assign w_wr_mtime_lo = w_wr & (w_idx == REG_MTIME_LO);
  assign w_wr_mtime_hi = w_wr & (w_idx == REG_MTIME_HI);
  assign w_wr_cmp_lo   = w_wr & (w_idx == REG_MTIMECMP_LO);
  assign w_wr_cmp_hi   = w_wr & (w_idx == REG_MTIMECMP_HI);

  // Only addr_i[4:2] select a register
  assign w_unused = ^{addr_i[31:5], addr_i[1:0]};

  clint_mtimer_prescaler u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_en),
    .i_div  (r_div),
    .i_clr  (w_wr_ctrl),
    .o_tick (w_tick)
  );

  // Compare on registered values; a set in the same cycle as a W1C wins.
  assign w_match    = (r_mtime >= r_mtimecmp);
  assign w_pend_nxt = (r_en & w_match) |
                      (r_pend & ~(w_wr_ctrl & data_i[CTRL_PEND_BIT]));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      REG_CTRL:        w_rdata = ctrl_pack(r_en, r_pend, r_div);
      REG_MTIME_LO:    w_rdata = r_mtime[31:0];
      REG_MTIME_HI:    w_rdata = r_hi_shadow;
      REG_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
      REG_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
      default:         w_rdata = '0;
    endcase
  end

  // A bus write to either half overrides a coincident tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtime <= '0;
    end else if (w_wr_mtime_lo) begin
      r_mtime[31:0] <= data_i;
    end else if (w_wr_mtime_hi) begin
      r_mtime[63:32] <= data_i;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtimecmp <= CMP_RESET;
    end else if (w_wr_cmp_lo) begin
      r_mtimecmp[31:0] <= data_i;
    end else if (w_wr_cmp_hi) begin
      r_mtimecmp[63:32] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_div      <= '0;
      r_pend     <= 1'b0;
      int_flag_o <= INT_NONE;
    end else begin
      if (w_wr_ctrl) begin
        r_en  <= data_i[CTRL_EN_BIT];
        r_div <= data_i[CTRL_DIV_LSB +: CTRL_DIV_W];
      end
      r_pend     <= w_pend_nxt;
      int_flag_o <= w_pend_nxt ? INT_MASK : INT_NONE;
    end
  end

  // Reading MTIME_LO snapshots the upper half for a tear-free 64-bit read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o      <= '0;
      rvalid_o    <= 1'b0;
      r_hi_shadow <= '0;
    end else begin
      rvalid_o <= w_rd;
      if (w_rd) begin
        data_o <= w_rdata;
        if (w_idx == REG_MTIME_LO) begin
          r_hi_shadow <= r_mtime[63:32];
        end
      end
    end
  end

endmodule

// File: tb/tb_clint_mtimer.sv
// Directed bench for clint_mtimer: stimulus is applied and sampled on the
// falling edge, so every bus access spans exactly one rising edge.
module tb_clint_mtimer;
  import clint_mtimer_pkg::*;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_MLO    = 32'h04;
  localparam logic [31:0] A_MHI    = 32'h08;
  localparam logic [31:0] A_CLO    = 32'h0C;
  localparam logic [31:0] A_CHI    = 32'h10;
  localparam logic [31:0] A_UNMAP5 = 32'h14;
  localparam logic [31:0] A_UNMAP7 = 32'h1C;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        rvalid_o;
  logic [7:0]  int_flag_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clint_mtimer dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .rvalid_o   (rvalid_o),
    .int_flag_o (int_flag_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    req_i  = 1'b1;
    we_i   = 1'b1;
    addr_i = a;
    data_i = d;
    @(negedge clk);
    req_i  = 1'b0;
    we_i   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = a;
    @(negedge clk);
    req_i  = 1'b0;
    check({tag, "_rvalid"}, {63'd0, rvalid_o}, 64'd1);
    check(tag, {32'd0, data_o}, {32'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    req_i  = 1'b0;
    we_i   = 1'b0;
    addr_i = '0;
    data_i = '0;
    #1;
    check("rst_int_flag", {56'd0, int_flag_o}, 64'd0);
    check("rst_rvalid",   {63'd0, rvalid_o}, 64'd0);
    check("rst_data",     {32'd0, data_o}, 64'd0);
    idle(2);
    rst = 1'b0;

    // Reset values over the bus
    rd("rst_ctrl", A_CTRL, 32'h0);
    rd("rst_cmp_hi", A_CHI, 32'hFFFF_FFFF);
    idle(1);
    check("rvalid_pulse", {63'd0, rvalid_o}, 64'd0);
    check("data_hold", {32'd0, data_o}, 64'hFFFF_FFFF);

    // DIV=0, mtimecmp=5: mtime==k after the k-th edge following the CTRL write
    wr(A_CHI, 32'h0);
    check("wr_no_rvalid", {63'd0, rvalid_o}, 64'd0);
    wr(A_CLO, 32'h5);
    wr(A_CTRL, 32'h1);
    idle(5);
    check("pend_not_yet", {56'd0, int_flag_o}, 64'd0);
    idle(1);
    check("pend_at_5", {56'd0, int_flag_o}, 64'h01);
    rd("mtime_6", A_MLO, 32'd6);
    check("pend_at_7", {56'd0, int_flag_o}, 64'h01);
    rd("ctrl_en_pend", A_CTRL, 32'h3);
    wr(A_CTRL, 32'h0);
    rd("mtime_frozen", A_MLO, 32'd9);
    idle(3);
    rd("mtime_still", A_MLO, 32'd9);
    check("pend_kept_en0", {56'd0, int_flag_o}, 64'h01);

    // Clear, then DIV=3 with a mid-period CTRL rewrite
    wr(A_CHI, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h2);
    check("w1c_clear", {56'd0, int_flag_o}, 64'd0);
    wr(A_MLO, 32'h0);
    wr(A_CTRL, 32'h0301);
    idle(3);
    rd("div3_before", A_MLO, 32'd0);
    rd("div3_first", A_MLO, 32'd1);
    idle(1);
    wr(A_CTRL, 32'h0301);
    idle(1);
    rd("div3_restart", A_MLO, 32'd1);
    idle(1);
    rd("div3_hold", A_MLO, 32'd1);
    rd("div3_second", A_MLO, 32'd2);

    // Atomic read across a low-word carry
    wr(A_CTRL, 32'h0);
    wr(A_MHI, 32'h0);
    wr(A_MLO, 32'hFFFF_FFFF);
    rd("carry_lo", A_MLO, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h1);
    rd("carry_hi_shadow", A_MHI, 32'h0);
    rd("carry_lo2", A_MLO, 32'h0);
    rd("carry_hi2", A_MHI, 32'h1);
    check("no_pend_carry", {56'd0, int_flag_o}, 64'd0);

    // Set wins over W1C; raising mtimecmp does not clear PEND
    wr(A_CHI, 32'h0);
    check("pend_latency", {56'd0, int_flag_o}, 64'd0);
    idle(1);
    check("pend_set", {56'd0, int_flag_o}, 64'h01);
    wr(A_CTRL, 32'h3);
    check("set_wins", {56'd0, int_flag_o}, 64'h01);
    rd("ctrl_set_wins", A_CTRL, 32'h3);
    wr(A_CHI, 32'hFFFF_FFFF);
    check("raise_cmp_keeps", {56'd0, int_flag_o}, 64'h01);
    wr(A_CTRL, 32'h3);
    check("w1c_after_raise", {56'd0, int_flag_o}, 64'd0);
    rd("ctrl_cleared", A_CTRL, 32'h1);

    // 64-bit wrap to zero
    wr(A_CTRL, 32'h0);
    wr(A_MHI, 32'hFFFF_FFFF);
    wr(A_MLO, 32'hFFFF_FFFF);
    check("match_needs_en", {56'd0, int_flag_o}, 64'd0);
    wr(A_CTRL, 32'h1);
    idle(1);
    rd("wrap_lo", A_MLO, 32'h0);
    rd("wrap_hi", A_MHI, 32'h0);
    check("pend_at_max", {56'd0, int_flag_o}, 64'h01);

    // A MTIME_LO write coinciding with a tick stores the written value
    wr(A_MLO, 32'h1234_5678);
    rd("wr_beats_tick", A_MLO, 32'h1234_5678);
    rd("tick_after_wr", A_MLO, 32'h1234_5679);

    // Unmapped indices
    wr(A_UNMAP7, 32'hDEAD_BEEF);
    rd("unmapped_5", A_UNMAP5, 32'h0);
    rd("unmapped_7", A_UNMAP7, 32'h0);

    // Reset asserted while a read is in flight
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = A_CLO;
    #2 rst = 1'b1;
    #1;
    check("midrst_int_flag", {56'd0, int_flag_o}, 64'd0);
    check("midrst_data", {32'd0, data_o}, 64'd0);
    @(negedge clk);
    req_i = 1'b0;
    check("midrst_rvalid", {63'd0, rvalid_o}, 64'd0);
    idle(1);
    rst = 1'b0;
    rd("post_rst_cmp_lo", A_CLO, 32'hFFFF_FFFF);
    rd("post_rst_mtime", A_MLO, 32'h0);
    rd("post_rst_ctrl", A_CTRL, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
